// File: rtl/division_pipeline.sv
// Pipelined restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// One quotient bit per stage, N stages plus an output register, one new operation per clock.
module division_pipeline #(
    parameter int N = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           in_valid,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           ovf
);

    // Stage k registers hold the state after quotient bit N-k has been decided.
    logic           vld_q [1:N];
    logic           ovf_q [1:N];
    logic [N-1:0]   rem_q [1:N];
    logic [N-1:0]   quo_q [1:N];
    logic [N-1:0]   low_q [1:N-1];
    logic [N-1:0]   dvs_q [1:N-1];

    logic [N:1]     take;
    logic [N-1:0]   rem_next [1:N];
    logic           ovf_in;

    assign ovf_in = (dividend[2*N-1:N] >= divisor);

    for (genvar k = 1; k <= N; k++) begin : g_stage
        logic [N-1:0] rem_in;
        logic         bit_in;
        logic [N-1:0] dvs_in;
        logic [N:0]   trial;
        logic [N:0]   diff;

        if (k == 1) begin : g_first
            assign rem_in = dividend[2*N-1:N];
            assign bit_in = dividend[N-1];
            assign dvs_in = divisor;
        end else begin : g_rest
            assign rem_in = rem_q[k-1];
            assign bit_in = low_q[k-1][N-1];
            assign dvs_in = dvs_q[k-1];
        end

        // Trial subtract is N+1 bits wide; the kept remainder always fits in N bits when ovf=0.
        assign trial       = {rem_in, bit_in};
        assign diff        = trial - {1'b0, dvs_in};
        assign take[k]     = (trial >= {1'b0, dvs_in});
        assign rem_next[k] = take[k] ? diff[N-1:0] : trial[N-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: every pipeline slot is cleared so no in-flight data survives reset; the
            // stage arrays are flops, not a RAM, so resetting them in a loop is legitimate.
            for (int k = 1; k <= N; k++) begin
                vld_q[k] <= 1'b0;
                ovf_q[k] <= 1'b0;
                rem_q[k] <= '0;
                quo_q[k] <= '0;
            end
            for (int k = 1; k < N; k++) begin
                low_q[k] <= '0;
                dvs_q[k] <= '0;
            end
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
        end else begin
            vld_q[1] <= in_valid;
            ovf_q[1] <= ovf_in;
            rem_q[1] <= rem_next[1];
            quo_q[1] <= {{(N-1){1'b0}}, take[1]};
            low_q[1] <= {dividend[N-2:0], 1'b0};
            dvs_q[1] <= divisor;

            for (int k = 2; k <= N; k++) begin
                vld_q[k] <= vld_q[k-1];
                ovf_q[k] <= ovf_q[k-1];
                rem_q[k] <= rem_next[k];
                quo_q[k] <= {quo_q[k-1][N-2:0], take[k]};
            end
            // Low dividend bits shift left so the next bit to bring down is always the MSB.
            for (int k = 2; k < N; k++) begin
                low_q[k] <= {low_q[k-1][N-2:0], 1'b0};
                dvs_q[k] <= dvs_q[k-1];
            end

            out_valid <= vld_q[N];
            ovf       <= ovf_q[N];
            quotient  <= ovf_q[N] ? '1 : quo_q[N];
            remainder <= ovf_q[N] ? '1 : rem_q[N];
        end
    end

endmodule

// File: tb/tb_division_pipeline.sv
// Scoreboard bench for division_pipeline: directed and random operations are queued at issue
// time and a negedge monitor compares every presented result and the out_valid timing.
module tb_division_pipeline;

    localparam int N = 8;

    logic           CLK;
    logic           RST;
    logic           in_valid;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           out_valid;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           ovf;

    typedef struct {
        logic [2*N-1:0] dvd;
        logic [N-1:0]   dvs;
        logic [N-1:0]   q;
        logic [N-1:0]   r;
        logic           ovf;
    } exp_t;

    exp_t        exp_q [$];
    logic [N:0]  vhist;
    int          n_checks;
    int          n_fail;

    division_pipeline #(.N(N)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference divider using plain arithmetic operators.
    function automatic exp_t model(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
        exp_t e;
        e.dvd = dvd;
        e.dvs = dvs;
        e.ovf = (dvd[2*N-1:N] >= dvs);
        if (e.ovf) begin
            e.q = '1;
            e.r = '1;
        end else begin
            e.q = N'(dvd / {8'd0, dvs});
            e.r = N'(dvd % {8'd0, dvs});
        end
        return e;
    endfunction

    // Reference out_valid timing: in_valid delayed by N+1 register edges, cleared by reset.
    always @(posedge CLK) begin
        if (RST) vhist <= '0;
        else     vhist <= {vhist[N-1:0], in_valid};
    end

    always @(negedge CLK) begin
        check("out_valid_timing", {31'd0, out_valid}, {31'd0, vhist[N]});
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quotient", {24'd0, quotient}, {24'd0, e.q});
                check("remainder", {24'd0, remainder}, {24'd0, e.r});
                check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                if (!e.ovf) begin
                    check("q*d+r", 32'(quotient) * 32'(e.dvs) + 32'(remainder), {16'd0, e.dvd});
                    check("multiplier_reconstruct", 32'(quotient) * 32'(e.dvs),
                          {16'd0, e.dvd} - 32'(e.r));
                    check("r<d", {31'd0, remainder < e.dvs}, 32'd1);
                end
            end
        end
    end

    task automatic issue(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                         input logic [N-1:0] q, input logic [N-1:0] r, input logic o);
        exp_t e;
        @(posedge CLK);
        #1;
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        e.dvd = dvd;
        e.dvs = dvs;
        e.q   = q;
        e.r   = r;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK);
            #1;
            in_valid = 1'b0;
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        in_valid = 1'b1;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);

        // Reset held two cycles with junk operands and in_valid high.
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_quotient", {24'd0, quotient}, 32'd0);
            check("rst_remainder", {24'd0, remainder}, 32'd0);
            check("rst_ovf", {31'd0, ovf}, 32'd0);
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
        end
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        in_valid = 1'b0;

        // Single op, then boundary and overflow vectors with hand-computed results.
        issue(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0);
        idle(N + 2);
        issue(16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0);
        issue(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0);
        issue(16'h0000, 8'h05, 8'h00, 8'h00, 1'b0);
        issue(16'h0700, 8'h07, 8'hFF, 8'hFF, 1'b1);
        issue(16'h1234, 8'h00, 8'hFF, 8'hFF, 1'b1);
        idle(N + 2);

        // Random stream: 20 ops with bubbles at cycles 5 and 11.
        for (int i = 0; i < 22; i++) begin
            if (i == 5 || i == 11) begin
                idle(1);
            end else begin
                logic [N-1:0]   dvs;
                logic [2*N-1:0] dvd;
                exp_t           e;
                dvs = 8'($urandom_range(1, 255));
                dvd = {8'($urandom_range(0, int'(dvs) - 1)), 8'($urandom)};
                if (i == 17) dvd[15:8] = dvs;
                e = model(dvd, dvs);
                issue(dvd, dvs, e.q, e.r, e.ovf);
            end
        end
        idle(N + 2);

        // Three ops in flight are flushed by a one-cycle reset.
        issue(16'd500, 8'd9, 8'd55, 8'd5, 1'b0);
        issue(16'd300, 8'd4, 8'd75, 8'd0, 1'b0);
        issue(16'd777, 8'd10, 8'd77, 8'd7, 1'b0);
        @(posedge CLK);
        #1;
        RST      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        issue(16'd2024, 8'd13, 8'd155, 8'd9, 1'b0);
        idle(N + 3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
